// File: rtl/dec_pkg.sv
// Shared widths and a reference one-hot helper for the 3-to-8 decoder.
package dec_pkg;

  localparam int unsigned DEC_IN_W  = 3;
  localparam int unsigned DEC_OUT_W = 1 << DEC_IN_W;

  function automatic logic [DEC_OUT_W-1:0] onehot_f(input logic [DEC_IN_W-1:0] idx);
    logic [DEC_OUT_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < DEC_OUT_W; k++) begin
      v[k] = (idx == DEC_IN_W'(k));
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_comb.sv
// Pure combinational binary-to-one-hot generator with selectable output polarity.
module decoder_comb #(
  parameter int unsigned IN_W       = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic [IN_W-1:0]      i_x,
  output logic [(1<<IN_W)-1:0] o_y
);

  localparam int unsigned OUT_W = 1 << IN_W;

  // Compare against every index instead of shifting, so no intermediate exceeds OUT_W.
  always_comb begin
    o_y = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      o_y[k] = (i_x == IN_W'(k)) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder; y comes only from the output register.
module decoder_3to8
  import dec_pkg::*;
#(
  parameter int unsigned IN_W       = DEC_IN_W,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      x,
  output logic [(1<<IN_W)-1:0] y
);

  localparam int unsigned OUT_W = 1 << IN_W;
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] w_dec;
  logic [OUT_W-1:0] w_next;
  logic [OUT_W-1:0] r_y;

  decoder_comb #(
    .IN_W      (IN_W),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_decoder_comb (
    .i_x(x),
    .o_y(w_dec)
  );

  // An unknown index deasserts every output in simulation; synthesis sees only the decode.
  always_comb begin
    w_next = w_dec;
`ifndef SYNTHESIS
    if ($isunknown(x)) begin
      w_next = INACTIVE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y <= INACTIVE;
    end else begin
      r_y <= w_next;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed and random checks of decoder_3to8 in both output polarities.
module tb_decoder_3to8;
  import dec_pkg::*;

  typedef struct {
    logic       rst_n;
    logic [2:0] x;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] x;
  logic [7:0] y;
  logic [7:0] y_al;

  int total = 0;
  int bad   = 0;

  decoder_3to8 #(.ACTIVE_LOW(1'b0)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .y    (y)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .y    (y_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    logic [7:0] exp;

    vecs[0]  = '{1'b0, 3'd5, 8'h00, "reset0"};
    vecs[1]  = '{1'b0, 3'd5, 8'h00, "reset1"};
    vecs[2]  = '{1'b1, 3'd0, 8'h01, "sweep0"};
    vecs[3]  = '{1'b1, 3'd1, 8'h02, "sweep1"};
    vecs[4]  = '{1'b1, 3'd2, 8'h04, "sweep2"};
    vecs[5]  = '{1'b1, 3'd3, 8'h08, "sweep3"};
    vecs[6]  = '{1'b1, 3'd4, 8'h10, "sweep4"};
    vecs[7]  = '{1'b1, 3'd5, 8'h20, "sweep5"};
    vecs[8]  = '{1'b1, 3'd6, 8'h40, "sweep6"};
    vecs[9]  = '{1'b1, 3'd7, 8'h80, "sweep7"};
    vecs[10] = '{1'b0, 3'd2, 8'h00, "rst_prio"};
    vecs[11] = '{1'b1, 3'd2, 8'h04, "rst_release"};
    vecs[12] = '{1'b1, 3'd7, 8'h80, "boundary7"};
    vecs[13] = '{1'b1, 3'd0, 8'h01, "boundary0"};

    rst_n = 1'b0;
    x     = 3'd5;

    for (int i = 0; i < 14; i++) begin
      rst_n = vecs[i].rst_n;
      x     = vecs[i].x;
      step();
      check(vecs[i].name, y, vecs[i].exp);
      check({vecs[i].name, "_al"}, y_al, ~vecs[i].exp);
    end

    // Input change between edges must not reach y until the next edge.
    x = 3'd3;
    step();
    check("lat_first", y, 8'h08);
    x = 3'd6;
    #2;
    check("lat_hold", y, 8'h08);
    check("lat_hold_al", y_al, 8'hF7);
    step();
    check("lat_next", y, 8'h40);

    // Unknown index deasserts all outputs where the simulator keeps X.
    x = 'x;
    step();
    if ($isunknown(x)) begin
      exp = 8'h00;
    end else begin
      exp = 8'h01 << x;
    end
    check("x_input", y, exp);
    check("x_input_al", y_al, ~exp);
    x = 3'd1;
    step();
    check("x_recover", y, 8'h02);

    for (int i = 0; i < 1000; i++) begin
      x = 3'($urandom_range(0, 7));
      step();
      exp = 8'h01 << x;
      check("rand_val", y, exp);
      total++;
      if (!$onehot(y) || !$onehot(~y_al)) begin
        bad++;
        $display("FAIL rand_onehot: got y=%h y_al=%h want one-hot", y, y_al);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
